// File: rtl/tone_oscillator.sv
// Per-voice tone oscillator: a 256-step phase accumulator that drives a square, saw, triangle
// or inverted-saw 8-bit sample. Define OSC_SYNC_EN to enable hard-sync on the sync input.
module tone_oscillator #(
    parameter int DIV_W  = 18,
    parameter int STEP_W = DIV_W - 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] divider,
    input  logic [1:0]       wave_sel,
    input  logic             sync,
    output logic [7:0]       sample,
    output logic             period_tick
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [DIV_W-1:0]  div_q;
    logic [STEP_W-1:0] cnt;
    logic [STEP_W-1:0] step_len;
    logic [7:0]        phase;
    logic [7:0]        wave;
    logic              step_done;

    // A zero step length would stall the phase, so it is clamped to one clock per step.
    assign step_len  = (div_q[DIV_W-1:8] == '0) ? STEP_W'(1) : div_q[DIV_W-1:8];
    assign step_done = (cnt == step_len - STEP_W'(1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wave = 8'h00;
        case (wave_sel)
            2'b00:   wave = phase[7] ? 8'hFF : 8'h00;
            2'b01:   wave = phase;
            2'b10:   wave = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
            default: wave = ~phase;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_q       <= '0;
            cnt         <= '0;
            phase       <= 8'h00;
            sample      <= 8'h00;
            period_tick <= 1'b0;
        end else begin
            period_tick <= 1'b0;
            case (state)
                IDLE: begin
                    cnt    <= '0;
                    phase  <= 8'h00;
                    sample <= 8'h00;
                    if (en) begin
                        state <= RUN;
                        div_q <= divider;
                    end
                end
                default: begin
                    if (!en) begin
                        // Gate-off beats a coincident wrap, so no tick is emitted.
                        state  <= IDLE;
                        cnt    <= '0;
                        phase  <= 8'h00;
                        sample <= 8'h00;
                    end else begin
                        sample <= wave;
`ifdef OSC_SYNC_EN
                        if (sync) begin
                            cnt   <= '0;
                            phase <= 8'h00;
                            div_q <= divider;
                        end else
`endif
                        if (step_done) begin
                            cnt   <= '0;
                            phase <= phase + 8'd1;
                            // Pitch changes take effect only at the wrap to stay glitch-free.
                            if (phase == 8'hFF) begin
                                div_q       <= divider;
                                period_tick <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + STEP_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // The low divider bits are truncated by design; sync is inert without OSC_SYNC_EN.
`ifdef OSC_SYNC_EN
    logic unused_bits;
    assign unused_bits = ^div_q[7:0];
`else
    logic unused_bits;
    assign unused_bits = ^{div_q[7:0], sync};
`endif

endmodule

// File: tb/tb_tone_oscillator.sv
// Directed bench for tone_oscillator: reset, saw timing, glitch-free pitch change, square,
// triangle, inverted saw, gate-off at wrap and hard-sync (behaviour follows OSC_SYNC_EN).
module tb_tone_oscillator;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [17:0] divider;
    logic [1:0]  wave_sel;
    logic        sync;
    logic [7:0]  sample;
    logic        period_tick;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int base       = 0;
    int rel;

    tone_oscillator dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .divider     (divider),
        .wave_sel    (wave_sel),
        .sync        (sync),
        .sample      (sample),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    // Step until period_tick is seen or the budget runs out; returns edges since base.
    task automatic wait_tick(input int max, output int at);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!period_tick && n < max);
        at = cyc - base;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; divider = 18'd0; wave_sel = 2'b00; sync = 1'b0;
        @(negedge clk);
        chk("reset_sample", sample, 8'd0);
        chk("reset_tick", period_tick, 1'b0);

        rst = 1'b0;
        step(1);
        chk("idle_sample", sample, 8'd0);

        // Saw at divider 512: two clocks per step, wrap every 512 clocks.
        en = 1'b1; divider = 18'd512; wave_sel = 2'b01;
        step(1); base = cyc;
        chk("saw_e0", sample, 8'd0);
        step(2);
        chk("saw_e2", sample, 8'd0);
        step(1);
        chk("saw_e3", sample, 8'd1);
        step(252);
        chk("saw_e255", sample, 8'd127);
        wait_tick(600, rel);
        chk("saw_tick1_pos", rel, 512);
        chk("saw_wrap_sample", sample, 8'd255);
        step(1);
        chk("tick_one_cycle", period_tick, 1'b0);
        chk("saw_after_wrap", sample, 8'd0);
        wait_tick(600, rel);
        chk("saw_tick2_pos", rel, 1024);

        // Pitch change mid-period: current period keeps 512, next one is 1024.
        step(200);
        divider = 18'd1024;
        step(1);
        chk("saw_phase100", sample, 8'd100);
        wait_tick(600, rel);
        chk("pitch_old_period", rel, 1536);
        step(41);
        chk("pitch_new_step", sample, 8'd10);
        wait_tick(1100, rel);
        chk("pitch_new_period", rel, 2560);
        chk("pre_rst_sample", sample, 8'd255);
        chk("pre_rst_tick", period_tick, 1'b1);

        // Asynchronous reset mid-run clears outputs without a clock edge.
        rst = 1'b1;
        #1;
        chk("async_rst_sample", sample, 8'd0);
        chk("async_rst_tick", period_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Square with divider 100 (step length clamps to 1).
        divider = 18'd100; wave_sel = 2'b00;
        step(1); base = cyc;
        step(1);
        chk("sq_e1", sample, 8'h00);
        step(127);
        chk("sq_e128", sample, 8'h00);
        step(1);
        chk("sq_e129", sample, 8'hFF);
        step(127);
        chk("sq_e256", sample, 8'hFF);
        chk("sq_tick", period_tick, 1'b1);
        step(1);
        chk("sq_e257", sample, 8'h00);

        // Triangle selected mid-run without phase reset; sample(E n) = tri((n-1) mod 256).
        wave_sel = 2'b10;
        step(64);
        chk("tri_phase64", sample, 8'd128);
        step(63);
        chk("tri_phase127", sample, 8'd254);
        step(65);
        chk("tri_phase192", sample, 8'd127);
        wave_sel = 2'b11;
        step(1);
        chk("isaw_phase193", sample, 8'h3E);

        // Gate off, then gate off exactly on a wrap edge: no tick.
        en = 1'b0;
        step(1);
        chk("gate_off_sample", sample, 8'd0);
        chk("gate_off_tick", period_tick, 1'b0);
        en = 1'b1; divider = 18'd100; wave_sel = 2'b01;
        step(1); base = cyc;
        step(255);
        chk("pre_wrap_sample", sample, 8'd254);
        en = 1'b0;
        step(1);
        chk("wrap_gate_tick", period_tick, 1'b0);
        chk("wrap_gate_sample", sample, 8'd0);
        step(3);
        chk("idle_hold", sample, 8'd0);

        // Hard sync at phase 80.
        en = 1'b1; divider = 18'd512; wave_sel = 2'b01;
        step(1); base = cyc;
        step(160);
        chk("sync_pre", sample, 8'd79);
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        chk("sync_edge_tick", period_tick, 1'b0);
        chk("sync_edge_sample", sample, 8'd80);
        step(1);
`ifdef OSC_SYNC_EN
        chk("sync_restart", sample, 8'd0);
        wait_tick(700, rel);
        chk("sync_tick_pos", rel, 673);
`else
        chk("sync_ignored", sample, 8'd80);
        wait_tick(700, rel);
        chk("sync_tick_pos", rel, 512);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
